// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the seven-segment scan path: digit-select encodings
// understood by the decoder, the scan FSM state type, default timing constants
// and the frame-load data mask.
// -----------------------------------------------------------------------------
package display_pkg;

    // Digit-select encodings consumed by the decoder.
    localparam logic [1:0] SEL_UPPER = 2'd0;  // upper nibble
    localparam logic [1:0] SEL_LOWER = 2'd1;  // lower nibble
    localparam logic [1:0] SEL_EXT   = 2'd2;  // extension bits [9:8]
    localparam logic [1:0] SEL_BLANK = 2'd3;  // all anodes off

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } scan_state_t;

    // 1 kHz per digit and a 10 us dark gap at 100 MHz.
    localparam int DEFAULT_DIGIT_TICKS = 100000;
    localparam int DEFAULT_BLANK_TICKS = 1000;
    localparam int DEFAULT_CNT_W       = 17;

    // In two-digit mode the extension bits are never shown, so they are
    // cleared on load to keep the snapshot a faithful copy of what is visible.
    function automatic logic [9:0] mask_word(input logic [9:0] word,
                                             input logic       ten_bit);
        return ten_bit ? word : {2'b00, word[7:0]};
    endfunction

endpackage

// File: rtl/scan_tick_counter.sv
// -----------------------------------------------------------------------------
// scan_tick_counter
// Loadable down-counter timing SHOW and BLANK intervals. Loading N-1 gives a
// terminal count after exactly N cycles; the counter parks at zero.
//
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   load      load load_val this cycle (takes priority over counting)
//   load_val  value loaded on load
//   tc        terminal count, high while the count is zero
// -----------------------------------------------------------------------------
module scan_tick_counter #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
// Time-multiplexing sequencer for the 4-digit seven-segment decoder. Steps the
// digit select through the digits of a frame with optional dark gaps between
// them, and presents a snapshot of the received word that only changes at a
// frame boundary so one frame never mixes two words.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   en          scan enable; low forces the display dark
//   ten_bit     1 = three-digit (10-bit) frame, 0 = two-digit (8-bit) frame
//   rx_data     received word; [9:8] only meaningful in ten-bit mode
//   rx_valid    single-cycle strobe qualifying rx_data
//   digit_sel   0 upper nibble, 1 lower nibble, 2 extension, 3 blank
//   disp_data   frame-stable snapshot for the decoder
//   frame_done  one-cycle pulse as a new frame starts after a complete scan
//   pending     a captured word is waiting for the next frame boundary
// -----------------------------------------------------------------------------
module display_scan_controller
    import display_pkg::*;
#(
    parameter int DIGIT_TICKS = DEFAULT_DIGIT_TICKS,
    parameter int BLANK_TICKS = DEFAULT_BLANK_TICKS,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       ten_bit,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [1:0] digit_sel,
    output logic [9:0] disp_data,
    output logic       frame_done,
    output logic       pending
);

    localparam bit               HAS_BLANK  = (BLANK_TICKS != 0);
    localparam logic [CNT_W-1:0] DIGIT_LOAD = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = HAS_BLANK ? CNT_W'(BLANK_TICKS - 1) : '0;

    scan_state_t      state;
    logic [1:0]       digit_idx;
    logic             mode;        // ten_bit latched at the last frame load
    logic [9:0]       hold;        // most recent word awaiting a boundary

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_tc;
    logic             last_digit;
    logic             advance;
    logic             frame_load;

    scan_tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .tc       (cnt_tc)
    );

    // Interval bookkeeping. The counter is reloaded on every state change and
    // forced to zero whenever the scan is idle or being disabled.
    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        last_digit   = (digit_idx == (mode ? SEL_EXT : SEL_LOWER));
        advance      = en && cnt_tc &&
                       ((state == BLANK) || (state == SHOW && !HAS_BLANK));
        frame_load   = (state == IDLE && en) || (advance && last_digit);
        cnt_load     = 1'b1;
        cnt_load_val = '0;
        case (state)
            IDLE: begin
                cnt_load_val = en ? DIGIT_LOAD : '0;
            end
            SHOW, BLANK: begin
                if (!en) begin
                    cnt_load_val = '0;
                end else if (cnt_tc) begin
                    cnt_load_val = (state == SHOW && HAS_BLANK) ? BLANK_LOAD : DIGIT_LOAD;
                end else begin
                    cnt_load = 1'b0;
                end
            end
            default: begin
                cnt_load_val = '0;
            end
        endcase
    end

    // NOTE: every register here is a small flop, not a memory array, so all of
    // them take a defined reset value and a reset also discards a pending word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            digit_idx  <= '0;
            mode       <= 1'b0;
            hold       <= '0;
            pending    <= 1'b0;
            disp_data  <= '0;
            digit_sel  <= SEL_BLANK;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // Capture runs regardless of scan state; last word wins.
            if (rx_valid) begin
                hold    <= rx_data;
                pending <= 1'b1;
            end

            // A word arriving on the load cycle bypasses the hold register,
            // so pending never rises for it.
            if (frame_load) begin
                mode <= ten_bit;
                if (rx_valid) begin
                    disp_data <= mask_word(rx_data, ten_bit);
                    pending   <= 1'b0;
                end else if (pending) begin
                    disp_data <= mask_word(hold, ten_bit);
                    pending   <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        state     <= SHOW;
                        digit_idx <= '0;
                        digit_sel <= SEL_UPPER;
                    end
                end
                SHOW, BLANK: begin
                    if (!en) begin
                        state     <= IDLE;
                        digit_idx <= '0;
                        digit_sel <= SEL_BLANK;
                    end else if (advance) begin
                        state <= SHOW;
                        if (last_digit) begin
                            digit_idx  <= '0;
                            digit_sel  <= SEL_UPPER;
                            frame_done <= 1'b1;
                        end else begin
                            digit_idx <= digit_idx + 2'd1;
                            digit_sel <= digit_idx + 2'd1;
                        end
                    end else if (state == SHOW && cnt_tc) begin
                        state     <= BLANK;
                        digit_sel <= SEL_BLANK;
                    end
                end
                default: begin
                    state     <= IDLE;
                    digit_idx <= '0;
                    digit_sel <= SEL_BLANK;
                end
            endcase
        end
    end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexing sequencer for the 4-digit seven-segment byte display decoder.
- Generates the 2-bit digit-select that the decoder consumes, inserts anti-ghosting blank intervals between digits and holds a frame-stable snapshot of received data.
- Snapshot updates only at frame boundaries, so digits of one frame never mix two words.
- Sits between the SPI receive path (word + valid strobe) and the display decoder.

Parameters:
- DIGIT_TICKS, 100000, clock cycles each digit is driven (1 kHz per digit at 100 MHz); legal range 1..2^CNT_W-1.
- BLANK_TICKS, 1000, clock cycles of all-off between digits; 0 disables blanking; legal range 0..2^CNT_W-1.
- CNT_W, 17, width of the internal tick counter; must hold max(DIGIT_TICKS, BLANK_TICKS)-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  scan enable; low forces display dark.
- ten_bit  input  1  1 = three-digit (10-bit) frame, 0 = two-digit (8-bit) frame.
- rx_data  input  10  received word; bits [9:8] are meaningful only in ten-bit mode.
- rx_valid  input  1  single-cycle strobe qualifying rx_data.
- digit_sel  output  2  to decoder Array: 0 upper nibble, 1 lower nibble, 2 extension bits, 3 blank (all anodes off).
- disp_data  output  10  frame-stable snapshot to the decoder data input.
- frame_done  output  1  one-cycle pulse at completion of each full scan.
- pending  output  1  a captured word is waiting for the next frame boundary.

Behaviour:
- Interface: one clock, clk. Reset is rst_n, synchronous, active-low. All state updates on the rising clk edge.
- Reset values: state IDLE, digit_sel=3, disp_data=0, frame_done=0, pending=0, tick counter=0, digit index=0, latched mode=0.
- Capture: on rx_valid, store rx_data in hold register and set pending=1. A later rx_valid before the boundary overwrites the hold register (last word wins).
- FSM states: IDLE, SHOW, BLANK.
- IDLE:
  - digit_sel=3.
  - When en=1, perform a frame load and enter SHOW with digit index 0 on the next cycle.
- SHOW:
  - digit_sel = digit index.
  - Held exactly DIGIT_TICKS cycles (counter 0..DIGIT_TICKS-1).
  - Then go to BLANK, or if BLANK_TICKS=0 advance directly.
- BLANK:
  - digit_sel=3.
  - Held exactly BLANK_TICKS cycles.
  - Then advance.
- Advance:
  - Last digit is 2 if latched mode=1, else 1.
  - If not last digit: index+1, enter SHOW.
  - If last digit: pulse frame_done for one cycle, perform frame load, index=0, enter SHOW.
- Frame load:
  - Latch ten_bit into latched mode.
  - If pending, disp_data = hold, with bits [9:8] forced to 0 when the new latched mode is 0; clear pending.
  - If rx_valid coincides with a frame load, the incoming rx_data is loaded directly and pending stays 0.
- ten_bit changes mid-frame take effect only at the next frame load.
- en low:
  - From SHOW or BLANK, enter IDLE on the next cycle.
  - digit_sel=3 from that cycle onward; counters and index are cleared.
  - disp_data, hold register and pending are retained; capture continues while disabled.
- Reset mid-frame returns all state to reset values on the same edge, including discarding a pending word.
- Latency:
  - en rising to first digit_sel=0: 1 cycle.
  - Frame period: (DIGIT_TICKS+BLANK_TICKS) × digits.
  - rx_valid to pending=1: 1 cycle.

Decomposition:
- Shared package display_pkg holds:
  - digit-select encodings SEL_UPPER=0, SEL_LOWER=1, SEL_EXT=2, SEL_BLANK=3;
  - state enum {IDLE, SHOW, BLANK};
  - default tick constants.
- One natural sub-module: scan_tick_counter. It is a loadable down-counter with a terminal-count output, reused for SHOW and BLANK durations.

Test Plan (DIGIT_TICKS=4, BLANK_TICKS=2, CNT_W=4):
- Reset then en=1, ten_bit=0, no data -> digit_sel sequence 0×4, 3×2, 1×4, 3×2 then repeat; frame_done pulses every 12 cycles; disp_data=0.
- ten_bit=1, rx_valid with rx_data=10'h2A5 mid-frame -> pending=1 next cycle; disp_data stays old until the frame_done cycle, then 10'h2A5; pending=0; frame period 18 cycles with digit_sel 0,1,2.
- ten_bit=0, rx_data=10'h3C7 -> disp_data=10'h0C7 at the next frame load.
- Two rx_valid pulses (10'h011 then 10'h122) within one frame -> only 10'h122 is loaded at the boundary.
- rx_valid=1 with 10'h055 on the exact frame-load cycle -> disp_data=10'h055 next cycle; pending never asserts.
- en dropped during SHOW of digit 1 -> digit_sel=3 next cycle and stays 3. Re-enabling restarts at digit 0 with full 4-cycle SHOW. BLANK_TICKS=0 run shows no 3 between digits.
